axi_dma_ltc2324_16: RTL and testbench

- Controls an LTC2324-16 4-channel, 16-bit serial ADC.
- Generates CNV and SCK, shifts in the four SDO lanes and packs each conversion into one 64-bit AXI4-Stream beat for a DMA engine.
- An acquisition of sample_len conversions starts on a host level request (sample_start); the block acknowledges it with st_clr.
- Sits between the ADC pins and the DMA S2MM stream port; single clock domain.

---
 rtl/axi_dma_ltc2324_16.sv | 276 +++++++++++++++++++++++++++
 tb/tb_axi_dma_ltc2324_16.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dma_ltc2324_16.sv
`default_nettype none
// ============================================================================
// Module   : axi_dma_ltc2324_16
// Purpose  : LTC2324-16 (4 x 16-bit serial ADC) front end. Generates CNV and
//            SCK, shifts in the four SDO lanes MSB first and packs every
//            conversion into one 64-bit AXI4-Stream beat for a DMA S2MM port.
//            An acquisition of sample_len conversions starts on a level
//            request (sample_start) and is acknowledged with a st_clr pulse.
// Ports    : adc_clk/adc_rst   - clock, synchronous active-high reset
//            adc_CNV/adc_SCK   - ADC convert strobe and serial clock (clk/2)
//            adc_SDO1..4       - serial data lanes, channel 1..4
//            adc_CLKOUT        - ADC echo clock, not used
//            sample_len        - conversions per acquisition (latched)
//            sample_start      - start request; st_clr - request accepted
//            DMA_AXIS_*        - 64-bit stream {ch4,ch3,ch2,ch1}
//            busy              - acquisition in progress
//            overflow          - sticky, a beat was dropped
// Revision : 1.0 - initial release
// ============================================================================
module axi_dma_ltc2324_16 #(
    parameter logic TEST_MODE    = 1'b0,
    parameter int   CNV_CYCLES   = 2,
    parameter int   CONV_WAIT    = 20,
    parameter int   FRAME_CYCLES = 55
) (
    input  logic        adc_clk,
    input  logic        adc_rst,
    output logic        adc_CNV,
    output logic        adc_SCK,
    input  logic        adc_CLKOUT,
    input  logic        adc_SDO1,
    input  logic        adc_SDO2,
    input  logic        adc_SDO3,
    input  logic        adc_SDO4,
    input  logic [31:0] sample_len,
    input  logic        sample_start,
    output logic        st_clr,
    output logic [63:0] DMA_AXIS_tdata,
    output logic [7:0]  DMA_AXIS_tkeep,
    output logic        DMA_AXIS_tvalid,
    output logic        DMA_AXIS_tlast,
    input  logic        DMA_AXIS_tready,
    output logic        busy,
    output logic        overflow
);

    localparam int c_cw = $clog2(FRAME_CYCLES + 1);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(FRAME_CYCLES - 1);
    localparam logic [c_cw-1:0] c_cnv_end  = c_cw'(CNV_CYCLES);
    localparam logic [c_cw-1:0] c_win_lo   = c_cw'(CNV_CYCLES + CONV_WAIT);
    localparam logic [c_cw-1:0] c_win_hi   = c_cw'(CNV_CYCLES + CONV_WAIT + 32);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_next;
    logic [31:0]     r_remaining;
    logic [13:0]     r_conv_idx;
    logic            r_cnv;
    logic            r_sck;
    logic            r_st_clr;
    logic            w_cnv_d;
    logic            w_sck_d;
    logic            w_accept;
    logic            w_frame_end;
    logic            w_final;
    logic            w_shift;
    logic            w_fire;
    logic            w_drain_done;
    logic [3:0]      w_sdo;
    logic [15:0]     r_sh [4];
    logic [15:0]     w_lane_word [4];
    logic [63:0]     w_word;

    // Output register and one-deep skid buffer
    logic            r_valid;
    logic [63:0]     r_data;
    logic            r_last;
    logic            r_sk_valid;
    logic [63:0]     r_sk_data;
    logic            r_sk_last;
    logic            r_overflow;

    logic            w_unused;
    assign w_unused = adc_CLKOUT;

    // The guard on r_st_clr gives the host one cycle to drop a level request
    // before a zero-length acquisition could be accepted a second time.
    assign w_accept     = (r_state == c_st_idle) && sample_start && !r_st_clr;
    assign w_frame_end  = (r_state == c_st_run) && (r_cnt == c_cnt_last);
    assign w_final      = w_frame_end && (r_remaining == 32'd1);
    assign w_fire       = r_valid && DMA_AXIS_tready;
    assign w_drain_done = !r_sk_valid && (!r_valid || DMA_AXIS_tready);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            c_st_idle: begin
                w_cnt_next = '0;
                if (w_accept && (sample_len != 32'd0)) begin
                    w_state_next = c_st_run;
                end
            end
            c_st_run: begin
                if (w_frame_end) begin
                    w_cnt_next = '0;
                    if (w_final) begin
                        w_state_next = c_st_drain;
                    end
                end else begin
                    w_cnt_next = r_cnt + c_cw'(1);
                end
            end
            c_st_drain: begin
                w_cnt_next = '0;
                if (w_drain_done) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. CNV/SCK are decoded from the next counter value and
    // then registered, so the pins are glitch-free and line up with the
    // counter value of the cycle in which they are visible.
    // ------------------------------------------------------------------
    always_comb begin
        w_cnv_d = 1'b0;
        w_sck_d = 1'b0;
        busy    = (r_state != c_st_idle);
        if (w_state_next == c_st_run) begin
            w_cnv_d = (w_cnt_next < c_cnv_end);
            // Odd offsets within the shift window: offset parity is the
            // counter LSB compared with the window start LSB.
            w_sck_d = (w_cnt_next >= c_win_lo) && (w_cnt_next < c_win_hi) &&
                      (w_cnt_next[0] ^ c_win_lo[0]);
        end
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_cnv    <= 1'b0;
            r_sck    <= 1'b0;
            r_st_clr <= 1'b0;
        end else begin
            r_cnv    <= w_cnv_d;
            r_sck    <= w_sck_d;
            r_st_clr <= w_accept;
        end
    end

    // Sample on the edge where SCK is driven from high to low.
    assign w_shift = r_sck && !w_sck_d;
    assign w_sdo   = {adc_SDO4, adc_SDO3, adc_SDO2, adc_SDO1};

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        always_ff @(posedge adc_clk) begin
            if (adc_rst) begin
                r_sh[gi] <= '0;
            end else if (w_shift) begin
                r_sh[gi] <= {r_sh[gi][14:0], w_sdo[gi]};
            end
        end
        assign w_lane_word[gi] = TEST_MODE ? {r_conv_idx, 2'(gi)} : r_sh[gi];
    end

    assign w_word = {w_lane_word[3], w_lane_word[2], w_lane_word[1], w_lane_word[0]};

    // ------------------------------------------------------------------
    // Acquisition bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_remaining <= '0;
            r_conv_idx  <= '0;
        end else if (w_accept) begin
            r_remaining <= sample_len;
            r_conv_idx  <= '0;
        end else if (w_frame_end) begin
            r_remaining <= r_remaining - 32'd1;
            r_conv_idx  <= r_conv_idx + 14'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output register + skid. A word arriving with both stages full and no
    // handshake is dropped; if it was the final word the held skid beat
    // inherits tlast so the packet is always terminated.
    // ------------------------------------------------------------------
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
            r_sk_last  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_overflow <= 1'b0;
            end
            if (w_fire) begin
                if (r_sk_valid) begin
                    r_data     <= r_sk_data;
                    r_last     <= r_sk_last;
                    r_sk_valid <= w_frame_end;
                    if (w_frame_end) begin
                        r_sk_data <= w_word;
                        r_sk_last <= w_final;
                    end
                end else if (w_frame_end) begin
                    r_data <= w_word;
                    r_last <= w_final;
                end else begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            end else if (!r_valid) begin
                if (w_frame_end) begin
                    r_valid <= 1'b1;
                    r_data  <= w_word;
                    r_last  <= w_final;
                end
            end else if (!r_sk_valid) begin
                if (w_frame_end) begin
                    r_sk_valid <= 1'b1;
                    r_sk_data  <= w_word;
                    r_sk_last  <= w_final;
                end
            end else if (w_frame_end) begin
                r_overflow <= 1'b1;
                if (w_final) begin
                    r_sk_last <= 1'b1;
                end
            end
        end
    end

    assign adc_CNV         = r_cnv;
    assign adc_SCK         = r_sck;
    assign st_clr          = r_st_clr;
    assign DMA_AXIS_tdata  = r_data;
    assign DMA_AXIS_tkeep  = 8'hFF;
    assign DMA_AXIS_tvalid = r_valid;
    assign DMA_AXIS_tlast  = r_last;
    assign overflow        = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_axi_dma_ltc2324_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_dma_ltc2324_16
// Purpose  : Self-checking bench. Two instances share all controls: one in
//            counter-pattern mode, one fed from fixed/floating/toggling SDO
//            lanes. A frame-level queue model predicts every output each
//            cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_dma_ltc2324_16;

    localparam int FR = 55;
    localparam int SW = 22;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sample_start;
    logic [31:0] sample_len;
    logic        tready;
    logic        sdo4 = 1'b0;
    always #2 sdo4 = ~sdo4;
    wire         sdo3 = 1'bz;

    logic        tm_cnv, tm_sck, tm_st_clr, tm_tvalid, tm_tlast, tm_busy, tm_ovf;
    logic [63:0] tm_tdata;
    logic [7:0]  tm_tkeep;
    logic        sd_cnv, sd_sck, sd_st_clr, sd_tvalid, sd_tlast, sd_busy, sd_ovf;
    logic [63:0] sd_tdata;
    logic [7:0]  sd_tkeep;

    axi_dma_ltc2324_16 #(.TEST_MODE(1'b1)) dut_tm (
        .adc_clk(clk), .adc_rst(rst), .adc_CNV(tm_cnv), .adc_SCK(tm_sck),
        .adc_CLKOUT(1'b0), .adc_SDO1(1'b0), .adc_SDO2(1'b1), .adc_SDO3(sdo3),
        .adc_SDO4(sdo4), .sample_len(sample_len), .sample_start(sample_start),
        .st_clr(tm_st_clr), .DMA_AXIS_tdata(tm_tdata), .DMA_AXIS_tkeep(tm_tkeep),
        .DMA_AXIS_tvalid(tm_tvalid), .DMA_AXIS_tlast(tm_tlast),
        .DMA_AXIS_tready(tready), .busy(tm_busy), .overflow(tm_ovf));

    axi_dma_ltc2324_16 #(.TEST_MODE(1'b0)) dut_sd (
        .adc_clk(clk), .adc_rst(rst), .adc_CNV(sd_cnv), .adc_SCK(sd_sck),
        .adc_CLKOUT(1'b0), .adc_SDO1(1'b0), .adc_SDO2(1'b1), .adc_SDO3(sdo3),
        .adc_SDO4(sdo4), .sample_len(sample_len), .sample_start(sample_start),
        .st_clr(sd_st_clr), .DMA_AXIS_tdata(sd_tdata), .DMA_AXIS_tkeep(sd_tkeep),
        .DMA_AXIS_tvalid(sd_tvalid), .DMA_AXIS_tlast(sd_tlast),
        .DMA_AXIS_tready(tready), .busy(sd_busy), .overflow(sd_ovf));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] tm_word(input int k);
        logic [13:0] kk;
        kk = k[13:0];
        return {kk, 2'd3, kk, 2'd2, kk, 2'd1, kk, 2'd0};
    endfunction

    // ------------------------------------------------------------------
    // Model: cycle index since st_clr gives frame and in-frame position;
    // finished conversions enter a 2-entry queue drained by tready.
    // ------------------------------------------------------------------
    typedef struct packed { logic [63:0] d; logic l; } beat_t;
    beat_t m_q[$];
    bit    m_en = 1'b0;
    bit    m_acq = 1'b0, m_busy = 1'b0, m_ovf = 1'b0, m_stclr = 1'b0;
    int    m_n = 0, m_len = 0;

    always @(negedge clk) begin : p_cmp
        int    c;
        int    k;
        bit    e_cnv, e_sck, acc, last;
        beat_t b;
        if (m_en) begin
            c     = m_n % FR;
            e_cnv = m_acq && (c < 2);
            e_sck = m_acq && (c >= SW) && (c < SW + 32) && (((c - SW) % 2) == 1);
            check("cnv",    {63'd0, tm_cnv},    {63'd0, e_cnv});
            check("sck",    {63'd0, tm_sck},    {63'd0, e_sck});
            check("st_clr", {63'd0, tm_st_clr}, {63'd0, m_stclr});
            check("busy",   {63'd0, tm_busy},   {63'd0, m_busy});
            check("ovf",    {63'd0, tm_ovf},    {63'd0, m_ovf});
            check("tvalid", {63'd0, tm_tvalid}, {63'd0, m_q.size() > 0});
            check("tkeep",  {56'd0, tm_tkeep},  64'hFF);
            check("sd_cnv",    {63'd0, sd_cnv},    {63'd0, e_cnv});
            check("sd_sck",    {63'd0, sd_sck},    {63'd0, e_sck});
            check("sd_tvalid", {63'd0, sd_tvalid}, {63'd0, m_q.size() > 0});
            check("sd_busy",   {63'd0, sd_busy},   {63'd0, m_busy});
            if (m_q.size() > 0) begin
                check("tdata",    tm_tdata, m_q[0].d);
                check("tlast",    {63'd0, tm_tlast}, {63'd0, m_q[0].l});
                check("sd_ch12",  {32'd0, sd_tdata[31:0]}, 64'hFFFF0000);
                check("sd_tlast", {63'd0, sd_tlast}, {63'd0, m_q[0].l});
            end
            // Advance to the next cycle using inputs sampled at the next edge.
            if (rst) begin
                m_q.delete();
                m_acq = 0; m_busy = 0; m_ovf = 0; m_stclr = 0; m_n = 0;
            end else begin
                acc = !m_busy && sample_start && !m_stclr;
                if (m_q.size() > 0 && tready) void'(m_q.pop_front());
                if (m_acq && c == FR - 1) begin
                    k    = m_n / FR;
                    last = (k == m_len - 1);
                    if (m_q.size() < 2) begin
                        b.d = tm_word(k);
                        b.l = last;
                        m_q.push_back(b);
                    end else begin
                        m_ovf = 1;
                        if (last) begin
                            b = m_q[1];
                            b.l = 1'b1;
                            m_q[1] = b;
                        end
                    end
                    if (last) m_acq = 0;
                end
                m_n++;
                m_busy  = m_acq || (m_busy && m_q.size() > 0);
                m_stclr = acc;
                if (acc) begin
                    m_ovf = 0;
                    if (sample_len != 0) begin
                        m_acq = 1; m_n = 0; m_len = int'(sample_len); m_busy = 1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture of delivered beats and pin activity for literal checks
    // ------------------------------------------------------------------
    typedef struct packed { logic [63:0] d; logic [31:0] sd; logic l; } cap_t;
    cap_t cap[$];
    int   cyc = 0, stclr_cyc = -1, first_vld = -1, n_cnv = 0, n_sck = 0;
    logic prev_sck = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : p_cap
        cap_t e;
        if (tm_st_clr) stclr_cyc = cyc;
        if (tm_tvalid && first_vld < 0) first_vld = cyc;
        if (tm_cnv) n_cnv++;
        if (tm_sck && !prev_sck) n_sck++;
        prev_sck = tm_sck;
        if (tm_tvalid && tready) begin
            e.d  = tm_tdata;
            e.sd = sd_tdata[31:0];
            e.l  = tm_tlast;
            cap.push_back(e);
        end
    end

    task automatic clear_caps();
        cap.delete();
        stclr_cyc = -1; first_vld = -1; n_cnv = 0; n_sck = 0;
    endtask

    task automatic run_acq(input int len, input int hold);
        @(posedge clk); #1;
        sample_len   = len;
        sample_start = 1'b1;
        @(posedge clk); #1;
        check("st_clr_pulse", {63'd0, tm_st_clr}, 64'd1);
        repeat (hold) @(posedge clk);
        #1 sample_start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit done;
        done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk); #1;
            if (!tm_busy) done = 1;
        end
        check("idle_timeout", {63'd0, done}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; sample_start = 1'b0; sample_len = '0; tready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_en = 1'b1;
        clear_caps();
        check("rst_cnv",    {63'd0, tm_cnv},    64'd0);
        check("rst_tdata",  tm_tdata,           64'd0);
        check("rst_busy",   {63'd0, tm_busy},   64'd0);
        repeat (9) @(posedge clk);
        check("rst_no_cnv", n_cnv, 64'd0);

        // Counter pattern, request held high after st_clr
        clear_caps();
        run_acq(3, 10);
        wait_idle(400);
        check("t1_beats", cap.size(), 64'd3);
        check("t1_b0", cap.size() > 0 ? cap[0].d : 64'd0, 64'h0003000200010000);
        check("t1_b1", cap.size() > 1 ? cap[1].d : 64'd0, 64'h0007000600050004);
        check("t1_b2", cap.size() > 2 ? cap[2].d : 64'd0, 64'h000B000A00090008);
        check("t1_lasts", cap.size() > 2 ? {61'd0, cap[0].l, cap[1].l, cap[2].l} : 64'd0, 64'd1);
        check("t1_sd_ch12", cap.size() > 0 ? {32'd0, cap[0].sd} : 64'd0, 64'hFFFF0000);
        check("t1_latency", first_vld - stclr_cyc, 64'd55);
        check("t1_cnv_cycles", n_cnv, 64'd6);
        check("t1_sck_pulses", n_sck, 64'd48);

        // Zero length
        clear_caps();
        run_acq(0, 0);
        repeat (20) @(posedge clk);
        #1;
        check("t0_busy", {63'd0, tm_busy}, 64'd0);
        check("t0_beats", cap.size(), 64'd0);

        // Back-pressure with overflow
        clear_caps();
        tready = 1'b0;
        run_acq(4, 0);
        repeat (4 * FR + 5) @(posedge clk);
        #1;
        check("ov_flag",   {63'd0, tm_ovf},    64'd1);
        check("ov_tvalid", {63'd0, tm_tvalid}, 64'd1);
        tready = 1'b1;
        wait_idle(50);
        check("ov_beats", cap.size(), 64'd2);
        check("ov_b0", cap.size() > 0 ? cap[0].d : 64'd0, 64'h0003000200010000);
        check("ov_b1", cap.size() > 1 ? cap[1].d : 64'd0, 64'h0007000600050004);
        check("ov_lasts", cap.size() > 1 ? {62'd0, cap[0].l, cap[1].l} : 64'd0, 64'd1);

        // Reset in the middle of frame 2, then a fresh acquisition
        clear_caps();
        run_acq(3, 0);
        repeat (FR + 20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mr_cnv",    {63'd0, tm_cnv},    64'd0);
        check("mr_sck",    {63'd0, tm_sck},    64'd0);
        check("mr_tvalid", {63'd0, tm_tvalid}, 64'd0);
        clear_caps();
        run_acq(3, 0);
        wait_idle(400);
        check("mr_beats", cap.size(), 64'd3);
        check("mr_b0", cap.size() > 0 ? cap[0].d : 64'd0, 64'h0003000200010000);
        check("mr_last", cap.size() > 2 ? {62'd0, cap[1].l, cap[2].l} : 64'd0, 64'd1);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
